// File: rtl/thread_dispatcher_pkg.sv
// ----------------------------------------------------------------------------
// thread_dispatcher_pkg
//   Shared definitions for the thread dispatcher, the context queue and the
//   execution core: bus widths, the queue-full threshold, the register-set
//   type that carries one thread context, and the dispatcher state encoding.
// ----------------------------------------------------------------------------
package thread_dispatcher_pkg;

    localparam int DATA_W   = 256;          // one register set
    localparam int NUM_REGS = 16;           // registers per context
    localparam int REG_W    = DATA_W / NUM_REGS;
    localparam int SIZE_W   = 16;           // queue occupancy width

    // Occupancy at or above which the queue refuses a push.
    localparam logic [SIZE_W-1:0] Q_FULL = 16'hfffe;

    // One thread context: 16 x 16-bit registers, register 0 in the low bits.
    typedef logic [NUM_REGS-1:0][REG_W-1:0] regset_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_LAUNCH,
        ST_RUN,
        ST_PREEMPT,
        ST_WRITEBACK
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/thread_dispatcher_if.sv
// ----------------------------------------------------------------------------
// thread_dispatcher_if
//   Queue and core handshake bundle around the dispatcher.
//   Queue side : q_size, q_err, q_data (valid the cycle after q_reading),
//                q_reading (pop strobe), q_adding / q_add_data (push).
//   Core side  : core_start (launch pulse), core_regs (context), core_preempt
//                (held until core_done), core_done / core_halted / core_result.
//   master = dispatcher, slave = queue + core.
// ----------------------------------------------------------------------------
interface thread_dispatcher_if;
    import thread_dispatcher_pkg::*;

    // queue
    logic [SIZE_W-1:0] q_size;
    logic              q_err;
    regset_t           q_data;
    logic              q_reading;
    logic              q_adding;
    regset_t           q_add_data;

    // core
    logic              core_start;
    regset_t           core_regs;
    logic              core_preempt;
    logic              core_done;
    logic              core_halted;
    regset_t           core_result;

    modport master (
        input  q_size, q_err, q_data,
        output q_reading, q_adding, q_add_data,
        output core_start, core_regs, core_preempt,
        input  core_done, core_halted, core_result
    );

    modport slave (
        output q_size, q_err, q_data,
        input  q_reading, q_adding, q_add_data,
        input  core_start, core_regs, core_preempt,
        output core_done, core_halted, core_result
    );

endinterface

// File: rtl/thread_dispatcher_slice_timer.sv
// ----------------------------------------------------------------------------
// thread_dispatcher_slice_timer
//   Counts core cycles of the current time slice.
//   clk, rst : clock, async active-high reset
//   clear    : zero the count (launch cycle)
//   en       : count this cycle (thread running)
//   expire   : en && count == QUANTUM-1, i.e. this is the last cycle of the
//              slice; the FSM leaves RUN on it, so the count never wraps.
// ----------------------------------------------------------------------------
module thread_dispatcher_slice_timer #(
    parameter int QUANTUM = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QUANTUM - 1);

    logic [CNT_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);
    assign expire  = en && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !at_last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/thread_dispatcher.sv
// ----------------------------------------------------------------------------
// thread_dispatcher
//   Pops thread contexts from the context queue, launches them on the core,
//   preempts a thread that overruns its QUANTUM-cycle slice, pushes
//   preempted/yielded threads back to the queue tail and retires halted ones.
//
//   clk, rst      : clock, async active-high reset (core must be reset too)
//   enable        : allows a new pop from IDLE; in-flight threads finish
//   bus           : queue + core handshake (master side)
//   busy          : high in every state except IDLE
//   retired_count : halted threads retired, saturating at 16'hffff
//   err           : sticky; q_err seen or core_done outside RUN/PREEMPT/WB
// ----------------------------------------------------------------------------
module thread_dispatcher
    import thread_dispatcher_pkg::*;
#(
    parameter int QUANTUM = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    thread_dispatcher_if.master  bus,
    output logic                 busy,
    output logic [15:0]          retired_count,
    output logic                 err
);

    state_e      state;
    logic        halted_q;
    logic [15:0] retired_q;
    logic        expire;
    logic        early_state;
    logic        push_ok;

    thread_dispatcher_slice_timer #(.QUANTUM(QUANTUM)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_LAUNCH),
        .en     (state == ST_RUN),
        .expire (expire)
    );

    // A done in these states cannot belong to a running thread.
    assign early_state = (state == ST_IDLE) || (state == ST_POP) ||
                         (state == ST_WAIT) || (state == ST_LAUNCH);

    // Occupancy is sampled live in WRITEBACK, so the push strobe is a decode
    // of the state register and q_size rather than a flop.
    assign push_ok      = (bus.q_size < Q_FULL);
    assign bus.q_adding = (state == ST_WRITEBACK) && !halted_q && push_ok;

    assign busy          = (state != ST_IDLE);
    assign retired_count = retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            bus.q_reading    <= 1'b0;
            bus.core_start   <= 1'b0;
            bus.core_preempt <= 1'b0;
            bus.core_regs    <= '0;
            bus.q_add_data   <= '0;
            halted_q         <= 1'b0;
            retired_q        <= 16'd0;
            err              <= 1'b0;
        end else begin
            bus.q_reading  <= 1'b0;
            bus.core_start <= 1'b0;

            if (bus.q_err || (bus.core_done && early_state)) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (enable && (bus.q_size != '0)) begin
                        bus.q_reading <= 1'b1;
                        state         <= ST_POP;
                    end
                end
                ST_POP: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    bus.core_regs  <= bus.q_data;
                    bus.core_start <= 1'b1;
                    state          <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // done takes priority over a coincident quantum expiry
                    if (bus.core_done) begin
                        bus.q_add_data <= bus.core_result;
                        halted_q       <= bus.core_halted;
                        state          <= ST_WRITEBACK;
                    end else if (expire) begin
                        bus.core_preempt <= 1'b1;
                        state            <= ST_PREEMPT;
                    end
                end
                ST_PREEMPT: begin
                    if (bus.core_done) begin
                        bus.core_preempt <= 1'b0;
                        bus.q_add_data   <= bus.core_result;
                        halted_q         <= bus.core_halted;
                        state            <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    if (halted_q) begin
                        retired_q <= sat_inc16(retired_q);
                        state     <= ST_IDLE;
                    end else if (push_ok) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_thread_dispatcher
//   Directed bench for thread_dispatcher with QUANTUM=4. Expected push data is
//   queued when the core result is driven and compared when q_adding fires.
// ----------------------------------------------------------------------------
module tb_thread_dispatcher;
    import thread_dispatcher_pkg::*;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [15:0] retired_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb[$];

    thread_dispatcher_if bus ();

    thread_dispatcher #(.QUANTUM(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .bus           (bus),
        .busy          (busy),
        .retired_count (retired_count),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the IDLE cycle; returns in the LAUNCH cycle.
    task automatic launch(input regset_t d, input logic [15:0] sz);
        bus.q_data = d;
        bus.q_size = sz;
        enable     = 1'b1;
        tick();                                   // POP
        chk1("pop_strobe", bus.q_reading, 1'b1);
        enable = 1'b0;
        tick();                                   // WAIT
        chk1("wait_no_start", bus.core_start, 1'b0);
        tick();                                   // LAUNCH
        chk1("launch_start", bus.core_start, 1'b1);
        chkv("launch_regs", bus.core_regs, d);
    endtask

    task automatic retire_one(input regset_t d);
        launch(d, 16'd1);
        tick();                                   // RUN
        bus.core_done   = 1'b1;
        bus.core_halted = 1'b1;
        bus.core_result = ~d;
        tick();                                   // WRITEBACK
        bus.core_done   = 1'b0;
        bus.core_halted = 1'b0;
        chk1("retire_no_push", bus.q_adding, 1'b0);
        tick();                                   // IDLE
        chk1("retire_idle", busy, 1'b0);
    endtask

    // Push monitor: every push must match the oldest expected context.
    always @(negedge clk) begin
        if (!rst) begin
            chk1("rd_add_excl", bus.q_reading & bus.q_adding, 1'b0);
            if (bus.q_adding) begin
                chk1("push_expected", logic'(sb.size() != 0), 1'b1);
                if (sb.size() != 0) chkv("push_data", bus.q_add_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        enable          = 1'b0;
        bus.q_size      = '0;
        bus.q_err       = 1'b0;
        bus.q_data      = '0;
        bus.core_done   = 1'b0;
        bus.core_halted = 1'b0;
        bus.core_result = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_reading", bus.q_reading, 1'b0);
        chk1("rst_adding", bus.q_adding, 1'b0);
        chk1("rst_start", bus.core_start, 1'b0);
        chk1("rst_preempt", bus.core_preempt, 1'b0);
        chkv("rst_regs", bus.core_regs, '0);
        chk16("rst_retired", retired_count, 16'd0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // single thread: pop at 1, launch at 3, done at 5, push at 6
        launch({32{8'ha5}}, 16'd1);               // cycle 3
        tick();                                   // cycle 4
        chk1("run_start_drop", bus.core_start, 1'b0);
        chk1("run_busy", busy, 1'b1);
        tick();                                   // cycle 5
        bus.core_done   = 1'b1;
        bus.core_halted = 1'b0;
        bus.core_result = {32{8'h11}};
        sb.push_back({32{8'h11}});
        tick();                                   // cycle 6 WRITEBACK
        bus.core_done = 1'b0;
        chk1("wb_push", bus.q_adding, 1'b1);
        chk1("wb_busy", busy, 1'b1);
        tick();                                   // cycle 7 IDLE
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_no_push", bus.q_adding, 1'b0);

        // retire and saturation
        retire_one({32{8'h22}});
        chk16("retired_one", retired_count, 16'd1);
        force dut.retired_q = 16'hfffe;
        tick();
        release dut.retired_q;
        tick();
        chk16("retired_preset", retired_count, 16'hfffe);
        retire_one({32{8'h23}});
        chk16("retired_max", retired_count, 16'hffff);
        retire_one({32{8'h24}});
        chk16("retired_sat", retired_count, 16'hffff);

        // preemption: QUANTUM RUN cycles, then preempt held until done
        launch({32{8'h44}}, 16'd1);               // L
        for (int i = 1; i <= 4; i++) begin        // L+1..L+4 in RUN
            tick();
            chk1("preempt_early", bus.core_preempt, 1'b0);
        end
        tick();                                   // L+5
        chk1("preempt_rise", bus.core_preempt, 1'b1);
        tick();                                   // L+6
        chk1("preempt_hold", bus.core_preempt, 1'b1);
        tick();                                   // L+7
        chk1("preempt_hold2", bus.core_preempt, 1'b1);
        bus.core_done   = 1'b1;
        bus.core_result = {32{8'h55}};
        sb.push_back({32{8'h55}});
        tick();                                   // WRITEBACK
        bus.core_done = 1'b0;
        chk1("preempt_drop", bus.core_preempt, 1'b0);
        chk1("preempt_requeue", bus.q_adding, 1'b1);
        tick();
        chk1("preempt_idle", busy, 1'b0);

        // done coincides with expiry: done wins, no preempt
        launch({32{8'h66}}, 16'd1);
        repeat (3) tick();
        tick();                                   // last slice cycle
        chk1("exp_no_preempt", bus.core_preempt, 1'b0);
        bus.core_done   = 1'b1;
        bus.core_result = {32{8'h77}};
        sb.push_back({32{8'h77}});
        tick();                                   // WRITEBACK
        bus.core_done = 1'b0;
        chk1("exp_wb_preempt", bus.core_preempt, 1'b0);
        chk1("exp_wb_push", bus.q_adding, 1'b1);
        tick();
        chk1("exp_idle", busy, 1'b0);
        chk1("exp_idle_preempt", bus.core_preempt, 1'b0);

        // full queue: stall ten cycles, then one push
        launch({32{8'h88}}, 16'hfffe);
        tick();                                   // RUN
        bus.core_done   = 1'b1;
        bus.core_result = {32{8'h99}};
        sb.push_back({32{8'h99}});
        tick();                                   // WRITEBACK
        bus.core_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk1("full_stall", bus.q_adding, 1'b0);
            chk1("full_busy", busy, 1'b1);
            tick();
        end
        bus.q_size = 16'hfffd;
        #1;
        chk1("full_release", bus.q_adding, 1'b1);
        tick();
        chk1("full_single", bus.q_adding, 1'b0);
        chk1("full_idle", busy, 1'b0);
        bus.q_size = '0;

        // reset during RUN
        launch({32{8'haa}}, 16'd1);
        tick();                                   // RUN
        rst = 1'b1;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_start", bus.core_start, 1'b0);
        chk1("mid_rst_preempt", bus.core_preempt, 1'b0);
        chk1("mid_rst_adding", bus.q_adding, 1'b0);
        chkv("mid_rst_regs", bus.core_regs, '0);
        chkv("mid_rst_add_data", bus.q_add_data, '0);
        chk16("mid_rst_retired", retired_count, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        chk1("mid_rst_idle", busy, 1'b0);

        // error paths
        chk1("err_clear", err, 1'b0);
        bus.q_err = 1'b1;
        tick();
        bus.q_err = 1'b0;
        chk1("err_qerr", err, 1'b1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk1("err_reset", err, 1'b0);
        tick();
        bus.core_done = 1'b1;                     // spurious, in IDLE
        tick();
        bus.core_done = 1'b0;
        chk1("err_spurious", err, 1'b1);
        chk1("err_spurious_idle", busy, 1'b0);
        repeat (3) tick();
        chk1("err_sticky", err, 1'b1);

        // empty queue: enable alone does not start a pop
        enable     = 1'b1;
        bus.q_size = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("empty_busy", busy, 1'b0);
            chk1("empty_no_pop", bus.q_reading, 1'b0);
        end
        enable = 1'b0;

        chk1("sb_drained", logic'(sb.size() == 0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
